sbox_sb: RTL and testbench



---
 rtl/sbox_sb_if.sv | 22 ++
 rtl/sbox_sb.sv | 87 ++++++++
 tb/tb_sbox_sb.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sbox_sb_if.sv
// Bus bundle for the SubBytes engine: input state with valid, registered output state with valid.
// The master drives in/in_valid; the slave (the engine) drives out/out_valid.
interface sbox_sb_if;
  logic       in_valid;
  logic [7:0] in  [3:0][3:0];
  logic       out_valid;
  logic [7:0] out [3:0][3:0];

  modport master (
    output in_valid,
    output in,
    input  out_valid,
    input  out
  );

  modport slave (
    input  in_valid,
    input  in,
    output out_valid,
    output out
  );
endinterface

// File: rtl/sbox_sb.sv
// AES forward SubBytes on a 4x4 state, 16 arithmetic S-box units feeding one output register.
// Latency 1 cycle, one state per cycle, no backpressure; out holds when in_valid is low.
module sbox_sb (
  input  logic     clk,
  input  logic     reset,
  sbox_sb_if.slave bus
);

  // GF(2^8) multiply, shift-and-add, reduced by 0x11B as the multiplicand shifts out of bit 7
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[7] ? ({sh[6:0], 1'b0} ^ 8'h1b) : {sh[6:0], 1'b0};
    end
    return acc;
  endfunction

  function automatic logic [7:0] gf_sq(input logic [7:0] a);
    return gf_mul(a, a);
  endfunction

  // x^254 by addition chain: 2,3,6,12,15,30,60,120,240,252,254. Zero maps to zero naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_sq(x);
    x3   = gf_mul(x2, x);
    x6   = gf_sq(x3);
    x12  = gf_sq(x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_sq(x15);
    x60  = gf_sq(x30);
    x120 = gf_sq(x60);
    x240 = gf_sq(x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  // y_i = b_i ^ b_(i+4) ^ b_(i+5) ^ b_(i+6) ^ b_(i+7) ^ 0x63, expressed as right-rotations of b
  function automatic logic [7:0] affine(input logic [7:0] b);
    return b
         ^ {b[3:0], b[7:4]}
         ^ {b[4:0], b[7:5]}
         ^ {b[5:0], b[7:6]}
         ^ {b[6:0], b[7]}
         ^ 8'h63;
  endfunction

  logic [7:0] sub   [3:0][3:0];
  logic [7:0] out_q [3:0][3:0];
  logic       vld_q;

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sub[r][c] = affine(gf_inv(bus.in[r][c]));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          out_q[r][c] <= 8'h00;
        end
      end
    end else begin
      vld_q <= bus.in_valid;
      if (bus.in_valid) begin
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            out_q[r][c] <= sub[r][c];
          end
        end
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_sbox_sb.sv
// Bench for sbox_sb: reference S-box built by brute-force inverse search, plus known FIPS-197 vectors.
module tb_sbox_sb;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sbox_sb_if bus ();
  sbox_sb dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sref  [256];
  logic [7:0] stim  [16];
  logic [7:0] m_out [16];
  logic       m_vld;
  logic [7:0] mix_in  [16];
  logic [7:0] mix_out [16];
  logic [7:0] bvals   [4];
  logic [7:0] bexp    [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Polynomial product then long-division reduction by 0x11B
  function automatic logic [7:0] pmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int k = 15; k >= 8; k--)
      if (p[k]) p = p ^ (16'h011b << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] y;
    inv = 8'h00;
    for (int v = 1; v < 256; v++)
      if (pmul(x, 8'(v)) == 8'h01) inv = 8'(v);
    for (int i = 0; i < 8; i++)
      y[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
    return y ^ 8'h63;
  endfunction

  task automatic apply();
    for (int k = 0; k < 16; k++) bus.in[k / 4][k % 4] = stim[k];
  endtask

  task automatic fill(input logic [7:0] v);
    for (int k = 0; k < 16; k++) stim[k] = v;
    apply();
  endtask

  task automatic rand_state();
    for (int k = 0; k < 16; k++) stim[k] = 8'($urandom_range(0, 255));
    apply();
  endtask

  // One clock: advance the reference on the edge, then compare every output just after it
  task automatic tick(input string tag);
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < 16; k++) m_out[k] = 8'h00;
      m_vld = 1'b0;
    end else if (bus.in_valid) begin
      for (int k = 0; k < 16; k++) m_out[k] = sref[bus.in[k / 4][k % 4]];
      m_vld = 1'b1;
    end else begin
      m_vld = 1'b0;
    end
    #1;
    chk($sformatf("%s out_valid", tag), 32'(bus.out_valid), 32'(m_vld));
    for (int k = 0; k < 16; k++)
      chk($sformatf("%s out[%0d][%0d]", tag, k / 4, k % 4), 32'(bus.out[k / 4][k % 4]), 32'(m_out[k]));
  endtask

  task automatic chk_const(input string tag, input logic [7:0] v);
    for (int k = 0; k < 16; k++)
      chk($sformatf("%s const[%0d][%0d]", tag, k / 4, k % 4), 32'(bus.out[k / 4][k % 4]), 32'(v));
  endtask

  initial begin
    mix_in  = '{8'h00, 8'h3C, 8'h6E, 8'h47, 8'h1F, 8'h4E, 8'h22, 8'h74,
                8'h0E, 8'h08, 8'h1B, 8'h31, 8'h54, 8'h59, 8'h0B, 8'h1A};
    mix_out = '{8'h63, 8'hEB, 8'h9F, 8'hA0, 8'hC0, 8'h2F, 8'h93, 8'h92,
                8'hAB, 8'h30, 8'hAF, 8'hC7, 8'h20, 8'hCB, 8'h2B, 8'hA2};
    bvals   = '{8'h00, 8'h01, 8'h53, 8'hFF};
    bexp    = '{8'h63, 8'h7C, 8'hED, 8'h16};
    for (int x = 0; x < 256; x++) sref[x] = sbox_model(8'(x));
    for (int k = 0; k < 16; k++) m_out[k] = 8'h00;
    m_vld = 1'b0;

    // Reset with valid input pending: reset wins
    reset = 1'b1;
    bus.in_valid = 1'b1;
    fill(8'hFF);
    tick("rst0");
    tick("rst1");
    chk_const("rst", 8'h00);
    chk("rst valid", 32'(bus.out_valid), 32'd0);
    reset = 1'b0;
    tick("release");
    chk_const("release", 8'h16);
    chk("release valid", 32'(bus.out_valid), 32'd1);

    // Mixed state against published vectors
    stim = mix_in;
    apply();
    tick("mix");
    for (int k = 0; k < 16; k++)
      chk($sformatf("mixvec[%0d][%0d]", k / 4, k % 4), 32'(bus.out[k / 4][k % 4]), 32'(mix_out[k]));

    // Boundary bytes
    for (int b = 0; b < 4; b++) begin
      fill(bvals[b]);
      tick($sformatf("bound%0h", bvals[b]));
      chk_const($sformatf("bound%0h", bvals[b]), bexp[b]);
    end

    // Exhaustive sweep, back-to-back
    for (int s = 0; s < 16; s++) begin
      for (int k = 0; k < 16; k++) stim[k] = 8'(16 * s + k);
      apply();
      tick($sformatf("sweep%0d", s));
    end

    // Hold with valid deasserted and changing input
    rand_state();
    tick("hold_load");
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_state();
      tick($sformatf("hold%0d", i));
    end

    // One-cycle reset in the middle of a valid stream
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      reset = (i == 3);
      rand_state();
      tick($sformatf("midrst%0d", i));
    end
    reset = 1'b0;

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 19) == 0);
      rand_state();
      tick($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
